// File: rtl/dma_rd_ar_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between two requesters, tagging ARID by index.
// Optional perf counters are enabled with the DMA_AR_ARB_PERF_EN macro.
module dma_rd_ar_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned MAX_OUT = 4,
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_arvalid,
  output logic              req0_arready,
  input  logic [ADDR_W-1:0] req0_araddr,
  input  logic [LEN_W-1:0]  req0_arlen,
  input  logic              req1_arvalid,
  output logic              req1_arready,
  input  logic [ADDR_W-1:0] req1_araddr,
  input  logic [LEN_W-1:0]  req1_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic              m_arid,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic              m_rid,
  input  logic              m_rlast,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              rsp0_rvalid,
  input  logic              rsp0_rready,
  output logic              rsp1_rvalid,
  input  logic              rsp1_rready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_rlast,
  output logic [CNT_W-1:0]  outstanding0,
  output logic [CNT_W-1:0]  outstanding1,
  output logic              protocol_err
`ifdef DMA_AR_ARB_PERF_EN
  ,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [31:0]       rr_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUT);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [LEN_W-1:0]    arlen_q, arlen_d;
  logic                arid_q, arid_d;
  logic [CNT_W-1:0]    out0_q, out0_d, out1_q, out1_d;
  logic                err_q, err_d;
  logic                elig0, elig1, gnt, ar_hs, rlast_hs;
  logic                inc0, inc1, dec0, dec1;

  // Simultaneous issue and completion on one requester cancel; underflow saturates at zero.
  function automatic logic [CNT_W-1:0] cnt_next(logic [CNT_W-1:0] cnt, logic inc, logic dec);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      nxt = cnt - CNT_W'(1);
    end
    return nxt;
  endfunction

  always_comb begin
    elig0 = req0_arvalid & (out0_q < MaxOut);
    elig1 = req1_arvalid & (out1_q < MaxOut);
    if (rr_q) begin
      gnt = elig1;
    end else begin
      gnt = ~elig0;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arid_d       = arid_q;
    req0_arready = 1'b0;
    req1_arready = 1'b0;
    ar_hs        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (elig0 || elig1) begin
          state_d      = StIssue;
          arvalid_d    = 1'b1;
          arid_d       = gnt;
          araddr_d     = gnt ? req1_araddr : req0_araddr;
          arlen_d      = gnt ? req1_arlen : req0_arlen;
          req0_arready = ~gnt;
          req1_arready = gnt;
        end
      end
      StIssue: begin
        if (arvalid_q && m_arready) begin
          ar_hs     = 1'b1;
          arvalid_d = 1'b0;
          rr_d      = ~arid_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rsp0_rvalid = m_rvalid & ~m_rid;
    rsp1_rvalid = m_rvalid & m_rid;
    m_rready    = m_rid ? rsp1_rready : rsp0_rready;
    rsp_rdata   = m_rdata;
    rsp_rlast   = m_rlast;
    rlast_hs    = m_rvalid & m_rready & m_rlast;
    inc0        = ar_hs & ~arid_q;
    inc1        = ar_hs & arid_q;
    dec0        = rlast_hs & ~m_rid;
    dec1        = rlast_hs & m_rid;
    out0_d      = cnt_next(out0_q, inc0, dec0);
    out1_d      = cnt_next(out1_q, inc1, dec1);
    err_d       = err_q | (dec0 & ~inc0 & (out0_q == '0)) | (dec1 & ~inc1 & (out1_q == '0));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rr_q      <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= 1'b0;
      out0_q    <= '0;
      out1_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arid_q    <= arid_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      err_q     <= err_d;
    end
  end

  assign m_arvalid    = arvalid_q;
  assign m_araddr     = araddr_q;
  assign m_arlen      = arlen_q;
  assign m_arid       = arid_q;
  assign outstanding0 = out0_q;
  assign outstanding1 = out1_q;
  assign protocol_err = err_q;

`ifdef DMA_AR_ARB_PERF_EN
  logic [31:0] gcnt0_q, gcnt1_q, stall_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      stall_q <= '0;
    end else begin
      if (inc0) gcnt0_q <= gcnt0_q + 32'd1;
      if (inc1) gcnt1_q <= gcnt1_q + 32'd1;
      if (arvalid_q && !m_arready) stall_q <= stall_q + 32'd1;
    end
  end

  assign grant_cnt0   = gcnt0_q;
  assign grant_cnt1   = gcnt1_q;
  assign rr_stall_cnt = stall_q;
`endif

endmodule
